// File: rtl/hack_rom_loader.sv
// Serial boot loader: assembles big-endian 16-bit words from a UART byte stream into the Hack ROM.
// Define HACK_LOADER_CHECKSUM_EN to require a trailing 8-bit two's-complement checksum byte.
module hack_rom_loader #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ADDR_W  = 15,
    parameter logic [7:0]  SYNC    = 8'h55,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [WIDTH-1:0]  rom_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int unsigned TmrW   = $clog2(TIMEOUT + 1);
    localparam int unsigned MaxLen = 1 << ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
`ifdef HACK_LOADER_CHECKSUM_EN
        StCksum,
`endif
        StFinish
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [15:0]       len_rx;
    logic              last_word;
    logic              timed_out;

    assign len_rx    = {len_q[15:8], rx_data};
    assign last_word = (32'(cnt_q) + 32'd1) == 32'(len_q);
    // FINISH is a one-cycle transit state and never waits for a byte.
    assign timed_out = (state_q != StIdle) && (state_q != StFinish) && !rx_valid &&
                       (tmr_q == TmrW'(TIMEOUT - 1));

`ifdef HACK_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d, sum_rx;

    assign sum_rx = sum_q + rx_data;

    always_comb begin
        sum_d = sum_q;
        if (state_q == StIdle) begin
            sum_d = 8'h00;
        end else if (rx_valid && (state_q == StLenHi || state_q == StLenLo ||
                                  state_q == StDataHi || state_q == StDataLo)) begin
            sum_d = sum_rx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;
        tmr_d       = (state_q == StIdle || rx_valid) ? '0 : tmr_q + TmrW'(1);

        unique case (state_q)
            StIdle: begin
                if (rx_valid && rx_data == SYNC) begin
                    state_d     = StLenHi;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    cpu_reset_d = 1'b1;
                    cnt_d       = '0;
                    addr_d      = '0;
                end
            end
            StLenHi: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (rx_valid) begin
                    len_d = len_rx;
                    if (len_rx == 16'd0 || 32'(len_rx) > MaxLen) begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                if (rx_valid) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = WIDTH'({hi_q, rx_data});
                    cnt_d   = cnt_q + 1'b1;
                    if (last_word) begin
`ifdef HACK_LOADER_CHECKSUM_EN
                        state_d = StCksum;
`else
                        state_d = StFinish;
`endif
                    end else begin
                        state_d = StDataHi;
                    end
                end
            end
`ifdef HACK_LOADER_CHECKSUM_EN
            StCksum: begin
                if (rx_valid) begin
                    if (sum_rx == 8'h00) begin
                        state_d = StFinish;
                    end else begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
`endif
            StFinish: begin
                done_d      = 1'b1;
                cpu_reset_d = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (timed_out) begin
            error_d = 1'b1;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            tmr_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            tmr_q       <= tmr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign rom_we    = we_q;
    assign rom_addr  = addr_q;
    assign rom_wdata = wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign error     = error_q;
endmodule

// File: tb/tb_hack_rom_loader.sv
// Randomized scoreboard bench for hack_rom_loader; a forked monitor checks every ROM write.
module tb_hack_rom_loader;
    localparam int unsigned TO = 40;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_reset, busy, done, error;

    hack_rom_loader #(
        .WIDTH  (16),
        .ADDR_W (15),
        .SYNC   (8'h55),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rom_we   (rom_we),
        .rom_addr (rom_addr),
        .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] words[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, rom_we, 0);
        check({tag, "_addr"}, rom_addr, 0);
        check({tag, "_wdata"}, rom_wdata, 0);
        check({tag, "_cpu_reset"}, cpu_reset, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    // Sends the frame for the current words[] list; a good frame lands word i at address i.
    task automatic send_frame(input int gap_max, input bit bad_ck);
        logic [15:0] n;
        logic [7:0]  sum;
        bit          exp_err;
        wr_t         e;
        n   = 16'(words.size());
        sum = n[15:8] + n[7:0];
        send_byte(8'h55);
        idle($urandom_range(gap_max, 0));
        send_byte(n[15:8]);
        idle($urandom_range(gap_max, 0));
        send_byte(n[7:0]);
        for (int i = 0; i < words.size(); i++) begin
            idle($urandom_range(gap_max, 0));
            send_byte(words[i][15:8]);
            idle($urandom_range(gap_max, 0));
            e.a = 15'(i);
            e.d = words[i];
            exp_q.push_back(e);
            send_byte(words[i][7:0]);
            sum = sum + words[i][15:8] + words[i][7:0];
        end
`ifdef HACK_LOADER_CHECKSUM_EN
        exp_err = bad_ck;
        idle($urandom_range(gap_max, 0));
        send_byte(bad_ck ? 8'(8'd1 - sum) : 8'(8'd0 - sum));
`else
        exp_err = 1'b0;
`endif
        @(negedge clk);
        check("done_early", done, 0);
        check("error_first", error, 32'(exp_err));
        @(negedge clk);
        check("done", done, 32'(!exp_err));
        check("cpu_reset_end", cpu_reset, 32'(exp_err));
        check("error_end", error, 32'(exp_err));
        check("busy_end", busy, 0);
        idle(2);
    endtask

    task automatic send_bad_len(input logic [7:0] hi, input logic [7:0] lo);
        send_byte(8'h55);
        send_byte(hi);
        send_byte(lo);
        @(negedge clk);
        check("len_error", error, 1);
        check("len_busy", busy, 0);
        check("len_cpu_reset", cpu_reset, 1);
        check("len_done", done, 0);
        idle(2);
    endtask

    initial begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset_n  = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("rst");
        idle(3);
        reset_n = 1'b1;

        fork
            begin
                wr_t e;
                forever begin
                    @(negedge clk);
                    if (rom_we) begin
                        if (exp_q.size() == 0) begin
                            check("spurious_we", 32'(rom_we), 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("wr_addr", 32'(rom_addr), 32'(e.a));
                            check("wr_data", 32'(rom_wdata), 32'(e.d));
                        end
                    end
                end
            end
        join_none

        // Directed two-word frame.
        words = {16'h1234, 16'hABCD};
        send_frame(0, 1'b0);

        // Illegal lengths: zero and above the 2^15-word ROM.
        send_bad_len(8'h00, 8'h00);
        send_bad_len(8'h80, 8'h01);

`ifdef HACK_LOADER_CHECKSUM_EN
        words = {16'h0007};
        send_frame(0, 1'b0);
        send_frame(0, 1'b1);
`endif

        // Stall inside DATA_HI of the second word until the timeout fires.
        begin
            wr_t e;
            send_byte(8'h55);
            send_byte(8'h00);
            send_byte(8'h02);
            send_byte(8'h12);
            e.a = 15'd0;
            e.d = 16'h1234;
            exp_q.push_back(e);
            send_byte(8'h34);
            send_byte(8'h56);
            repeat (TO - 1) @(posedge clk);
            @(negedge clk);
            check("to_not_yet", error, 0);
            check("to_busy", busy, 1);
            @(negedge clk);
            check("to_error", error, 1);
            check("to_idle", busy, 0);
            check("to_cpu_reset", cpu_reset, 1);
        end
        words = {16'hBEEF, 16'h0001, 16'hFFFF};
        send_frame(1, 1'b0);

        // Asynchronous reset after three of five words.
        words.delete();
        repeat (5) words.push_back(16'($urandom));
        begin
            wr_t e;
            send_byte(8'h55);
            send_byte(8'h00);
            send_byte(8'h05);
            for (int i = 0; i < 3; i++) begin
                send_byte(words[i][15:8]);
                e.a = 15'(i);
                e.d = words[i];
                exp_q.push_back(e);
                send_byte(words[i][7:0]);
            end
            send_byte(words[3][15:8]);
            @(negedge clk);
            reset_n = 1'b0;
            #1;
            check_reset_values("midrst");
            idle(3);
            reset_n = 1'b1;
            check("midrst_pending", exp_q.size(), 0);
        end
        send_frame(0, 1'b0);

        // Stray bytes in IDLE are ignored, then a back-to-back frame.
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hFF);
        @(negedge clk);
        check("stray_busy", busy, 0);
        words = {16'h5555, 16'h0055, 16'h7FFF};
        send_frame(0, 1'b0);

        // Randomized frames with random inter-byte gaps.
        for (int k = 0; k < 8; k++) begin
            bit bad;
            words.delete();
            repeat ($urandom_range(6, 1)) words.push_back(16'($urandom));
            bad = 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
            bad = ($urandom_range(3, 0) == 0);
`endif
            send_frame(3, bad);
        end

        idle(3);
        check("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hack_rom_loader.md
# hack_rom_loader

Serial boot loader upstream of the Hack CPU's instruction ROM. Consumes a byte stream from the UART receiver, assembles 16-bit big-endian instruction words, writes them to the instruction ROM write port from address 0 upward, and holds the CPU in reset until a complete, valid program has landed. Released CPU reset is the only path from loader to core.

## Interface
- WIDTH, 16: instruction word width; fixed at 16, two bytes per word.
- ADDR_W, 15: ROM address width; maximum program length is 2^ADDR_W words.
- SYNC, 8'h55: frame start byte.
- TIMEOUT, 1_000_000: idle clock cycles allowed between bytes inside a frame.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle pulse; rx_data valid.
- rx_data  in  8  received byte.
- rom_we  out  1  ROM write strobe, one cycle per word.
- rom_addr  out  ADDR_W  ROM write address.
- rom_wdata  out  WIDTH  ROM write data.
- cpu_reset  out  1  active-high reset to the CPU; 1 while not ready.
- busy  out  1  frame in progress.
- done  out  1  last frame loaded successfully.
- error  out  1  last frame aborted; sticky until next SYNC.

## Operation
- Frame: SYNC, LEN_HI, LEN_LO, then N words of DATA_HI and DATA_LO, where N = {LEN_HI, LEN_LO}. Under CHECKSUM_EN, one CKSUM byte follows.
- States and transitions:
  - IDLE: on SYNC, go to LEN_HI, clear done and error, assert cpu_reset, and set the word counter and rom_addr to 0. Any other byte is ignored.
  - LEN_HI, then LEN_LO: when LEN_LO is accepted, if N == 0 or N > 2^ADDR_W, raise error and go to IDLE. Otherwise go to DATA_HI.
  - DATA_HI: latch the high byte.
  - DATA_LO: form the word {hi, lo} and issue a write. After word N, go to CKSUM if CHECKSUM_EN is defined, else to FINISH. Otherwise return to DATA_HI.
  - CKSUM: go to FINISH if the check passes, else raise error and go to IDLE.
  - FINISH: set done, deassert cpu_reset, and go to IDLE.
- Writes: rom_addr equals the word index. rom_wdata and rom_addr are held stable after a write until the next write.
- SYNC inside a frame: treated as ordinary data, not a restart.
- Timeout: in any state except IDLE, TIMEOUT cycles without rx_valid raise error and return to IDLE. The counter clears on every accepted byte.
- cpu_reset after error: stays 1. The CPU does not run a partial program.
- Outputs: busy = (state != IDLE).

## Timing
- Reset values: rom_we = 0, rom_addr = 0, rom_wdata = 0, cpu_reset = 1, busy = 0, done = 0, error = 0. State resets to IDLE.
- Bytes: accepted on the rising edge where rx_valid = 1. rx_valid may be asserted on consecutive cycles.
- rom_we: registered. It pulses for exactly one cycle, starting on the cycle after the DATA_LO byte is accepted, with rom_addr and rom_wdata valid in that cycle.
- Final word: done rises and cpu_reset falls 2 cycles after the last DATA_LO byte is accepted (one cycle later than the rom_we pulse). Under CHECKSUM_EN, the same applies 2 cycles after the CKSUM byte.
- error: rises 1 cycle after the offending byte or the timeout cycle.
- reset_n mid-frame: all state clears immediately, cpu_reset returns to 1, and no further writes are issued.

## Configuration
- HACK_LOADER_CHECKSUM_EN defined:
  - An 8-bit running sum covers LEN_HI, LEN_LO and every data byte.
  - The frame passes only if (sum + CKSUM) mod 256 == 0.
  - On mismatch, ROM contents are already overwritten, error = 1 and cpu_reset stays 1.
- HACK_LOADER_CHECKSUM_EN not defined: there is no CKSUM byte or CKSUM state. Completion follows immediately after word N.

## Test plan
- 55 00 02 12 34 AB CD (no checksum) -> writes 0x1234 @0 and 0xABCD @1; done = 1 and cpu_reset = 0 two cycles after the CD byte is accepted.
- Length 0 (55 00 00) -> error = 1 one cycle after LEN_LO; no rom_we pulses; cpu_reset = 1. Repeat with 55 80 01 (N = 0x8001 > 2^15 for ADDR_W = 15) -> same response.
- With checksum, 55 00 01 00 07 F8 -> pass with done = 1. The same frame with final byte F9 -> error = 1, cpu_reset = 1, and ROM @0 = 0x0007.
- Frame stalls after DATA_HI for TIMEOUT cycles -> error = 1, state returns to IDLE, and the next valid frame loads correctly.
- reset_n pulsed low mid-frame after 3 of 5 words -> all outputs at reset values; the subsequent full frame rewrites from address 0.
- Stray bytes (00 AA FF) in IDLE, then a valid frame -> stray bytes ignored; the frame loads normally with back-to-back rx_valid.
